// File: rtl/clock_ratio_pkg.sv
// Shared types for the divided-clock ratio monitor.
package clock_ratio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        MEASURE,
        LOCKED,
        FAULT
    } state_t;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser with a both-edge pulse on the synchronised level.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic edge_pulse
);

    logic meta;
    logic sync;
    logic dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            dly  <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign level      = sync;
    assign edge_pulse = sync ^ dly;

endmodule

// File: rtl/clock_ratio_monitor.sv
// Measures divided-clock half-periods, locks on the expected ratio, flags faults.
// Optional RATIO_MON_STATS_EN adds a saturating fault_cnt output.
module clock_ratio_monitor
    import clock_ratio_pkg::*;
#(
    parameter  int EXPECTED_DIV   = 4,
    parameter  int TOL            = 0,
    parameter  int LOCK_COUNT     = 4,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int CNT_W          = cnt_width(TIMEOUT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             en,
    input  logic             err_clr,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             err
`ifdef RATIO_MON_STATS_EN
    ,
    output logic [7:0]       fault_cnt
`endif
);

    localparam int MATCH_W = cnt_width(LOCK_COUNT);
    localparam logic [CNT_W:0]     HALF_EXP = (CNT_W+1)'(EXPECTED_DIV / 2);
    localparam logic [CNT_W:0]     TOL_W    = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [MATCH_W-1:0] LOCK_N   = MATCH_W'(LOCK_COUNT);

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_n;
    logic [CNT_W-1:0]   hp_n;
    logic               pv_n;
    logic               err_n;
    logic               edge_pulse;
    logic [CNT_W:0]     cnt_x;
    logic [CNT_W:0]     diff;
    logic               is_match;
    logic               timeout;

    sync_edge_detect u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (clk_in),
        .level      (),
        .edge_pulse (edge_pulse)
    );

    // One extra bit keeps the distance from HALF_EXP free of wrap-around.
    always_comb begin
        cnt_x    = {1'b0, cnt};
        diff     = (cnt_x >= HALF_EXP) ? cnt_x - HALF_EXP : HALF_EXP - cnt_x;
        is_match = (diff <= TOL_W);
        timeout  = (cnt == CNT_MAX);
    end

    always_comb begin
        state_n = state;
        match_n = match_cnt;
        hp_n    = half_period;
        pv_n    = 1'b0;
        err_n   = err;
        if (edge_pulse)
            cnt_n = CNT_W'(1);
        else if (timeout)
            cnt_n = cnt;
        else
            cnt_n = cnt + CNT_W'(1);

        if (!en) begin
            state_n = IDLE;
            match_n = '0;
            cnt_n   = '0;
            if (state == FAULT && err_clr)
                err_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: state_n = SYNC;
                SYNC: begin
                    if (edge_pulse) begin
                        state_n = MEASURE;
                        match_n = '0;
                    end else if (timeout) begin
                        state_n = FAULT;
                    end
                end
                MEASURE: begin
                    if (edge_pulse) begin
                        hp_n = cnt;
                        pv_n = 1'b1;
                        if (is_match) begin
                            match_n = match_cnt + MATCH_W'(1);
                            if (match_n == LOCK_N)
                                state_n = LOCKED;
                        end else begin
                            match_n = '0;
                        end
                    end else if (timeout) begin
                        state_n = FAULT;
                    end
                end
                LOCKED: begin
                    if (edge_pulse) begin
                        hp_n = cnt;
                        pv_n = 1'b1;
                        if (!is_match)
                            state_n = FAULT;
                    end else if (timeout) begin
                        state_n = FAULT;
                    end
                end
                FAULT: begin
                    if (err_clr) begin
                        state_n = SYNC;
                        err_n   = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (state_n == FAULT)
            err_n = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            match_cnt    <= match_n;
            half_period  <= hp_n;
            period_valid <= pv_n;
            locked       <= (state_n == LOCKED);
            err          <= err_n;
        end
    end

`ifdef RATIO_MON_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault_cnt <= '0;
        else if (state_n == FAULT && state != FAULT && fault_cnt != 8'hFF)
            fault_cnt <= fault_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Randomised bench for clock_ratio_monitor with a timestamp-based reference model.
module tb_clock_ratio_monitor;

    localparam int TO   = 255;
    localparam int HALF = 2;
    localparam int LC   = 4;
    localparam int M_IDLE = 0, M_SYNC = 1, M_MEAS = 2, M_LOCK = 3, M_FAULT = 4;

    logic clk = 0, rst_n = 0, clk_in = 0, en = 0, err_clr = 0;
    logic [7:0] hp0, hp1;
    logic pv0, pv1, lk0, lk1, er0, er1;
`ifdef RATIO_MON_STATS_EN
    logic [7:0] fc0, fc1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_ratio_monitor #(.EXPECTED_DIV(4), .TOL(0), .LOCK_COUNT(LC),
                          .TIMEOUT_CYCLES(TO)) u0 (
        .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .en(en),
        .err_clr(err_clr), .half_period(hp0), .period_valid(pv0),
        .locked(lk0), .err(er0)
`ifdef RATIO_MON_STATS_EN
        , .fault_cnt(fc0)
`endif
    );

    clock_ratio_monitor #(.EXPECTED_DIV(4), .TOL(1), .LOCK_COUNT(LC),
                          .TIMEOUT_CYCLES(TO)) u1 (
        .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .en(en),
        .err_clr(err_clr), .half_period(hp1), .period_valid(pv1),
        .locked(lk1), .err(er1)
`ifdef RATIO_MON_STATS_EN
        , .fault_cnt(fc1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: cnt is the distance from the last edge (timestamp), clipped at TO.
    int n = 0, base = 1;
    int h[3] = '{0, 0, 0};
    int tol[2] = '{0, 1};
    int m_mode[2], m_match[2], m_hp[2], m_pv[2], m_lk[2], m_err[2], m_fc[2];
    int e, c, d, nm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = M_IDLE; m_match[i] = 0; m_hp[i] = 0;
                m_pv[i] = 0; m_lk[i] = 0; m_err[i] = 0; m_fc[i] = 0;
            end
            h = '{0, 0, 0};
            base = n + 1;
        end else begin
            n++;
            e = h[1] ^ h[2];
            c = n - base;
            if (c > TO) c = TO;
            d = (c > HALF) ? c - HALF : HALF - c;
            for (int i = 0; i < 2; i++) begin
                nm = m_mode[i];
                m_pv[i] = 0;
                if (!en) begin
                    if (m_mode[i] == M_FAULT && err_clr) m_err[i] = 0;
                    nm = M_IDLE;
                    m_match[i] = 0;
                end else begin
                    case (m_mode[i])
                        M_IDLE: nm = M_SYNC;
                        M_SYNC: begin
                            if (e) begin nm = M_MEAS; m_match[i] = 0; end
                            else if (c == TO) nm = M_FAULT;
                        end
                        M_MEAS: begin
                            if (e) begin
                                m_hp[i] = c; m_pv[i] = 1;
                                if (d <= tol[i]) begin
                                    m_match[i]++;
                                    if (m_match[i] == LC) nm = M_LOCK;
                                end else m_match[i] = 0;
                            end else if (c == TO) nm = M_FAULT;
                        end
                        M_LOCK: begin
                            if (e) begin
                                m_hp[i] = c; m_pv[i] = 1;
                                if (d > tol[i]) nm = M_FAULT;
                            end else if (c == TO) nm = M_FAULT;
                        end
                        default: if (err_clr) begin nm = M_SYNC; m_err[i] = 0; end
                    endcase
                end
                if (nm == M_FAULT) begin
                    m_err[i] = 1;
                    if (m_mode[i] != M_FAULT && m_fc[i] < 255) m_fc[i]++;
                end
                m_mode[i] = nm;
                m_lk[i] = (nm == M_LOCK);
            end
            if (!en) base = n + 1;
            else if (e) base = n;
            h[2] = h[1]; h[1] = h[0]; h[0] = int'(clk_in);
        end
    end

    always begin
        @(posedge clk);
        #2;
        chk("hp0", hp0, m_hp[0]);  chk("pv0", pv0, m_pv[0]);
        chk("lk0", lk0, m_lk[0]);  chk("er0", er0, m_err[0]);
        chk("hp1", hp1, m_hp[1]);  chk("pv1", pv1, m_pv[1]);
        chk("lk1", lk1, m_lk[1]);  chk("er1", er1, m_err[1]);
`ifdef RATIO_MON_STATS_EN
        chk("fc0", fc0, m_fc[0]);  chk("fc1", fc1, m_fc[1]);
`endif
    end

    task automatic div_run(input int half, input int halves);
        repeat (halves) begin
            repeat (half) @(negedge clk);
            clk_in = ~clk_in;
        end
    endtask

    task automatic alt_run(input int halves);
        for (int k = 0; k < halves; k++) begin
            repeat ((k % 2 == 0) ? 2 : 3) @(negedge clk);
            clk_in = ~clk_in;
        end
    endtask

    task automatic hold(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk) err_clr = 1;
        @(negedge clk) err_clr = 0;
    endtask

    initial begin
        hold(4);
        chk("rst_hp", hp0, 0); chk("rst_pv", pv0, 0);
        chk("rst_lk", lk0, 0); chk("rst_er", er0, 0);
        rst_n = 1;
        hold(2);
        en = 1;

        div_run(2, 40);
        chk("lock_div4", lk0, 1); chk("hp_div4", hp0, 2); chk("err_div4", er0, 0);

        div_run(4, 4);
        chk("ratio_err", er0, 1); chk("ratio_unlk", lk0, 0); chk("ratio_hp", hp0, 4);

        pulse_clr();
        div_run(2, 40);
        chk("relock", lk0, 1); chk("relock_err", er0, 0);

        hold(300);
        chk("to_err", er0, 1); chk("to_hp", hp0, 2); chk("to_unlk", lk0, 0);

        div_run(2, 2);
        pulse_clr();
        alt_run(40);
        chk("tol1_lock", lk1, 1); chk("tol0_nolock", lk0, 0); chk("tol0_err", er0, 0);

        en = 0;
        hold(5);
        en = 1;
        div_run(2, 3);
        chk("reen_nolock", lk0, 0);
        div_run(2, 20);
        chk("reen_lock", lk0, 1);

        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: div_run($urandom_range(1, 6), $urandom_range(2, 12));
                6: begin en = 0; hold($urandom_range(1, 5)); en = 1; end
                7: pulse_clr();
                8: hold($urandom_range(10, 300));
                default: begin
                    if ($urandom_range(0, 1) == 1) err_clr = 1;
                    en = ($urandom_range(0, 3) != 0);
                    hold(1);
                    err_clr = 0; en = 1;
                end
            endcase
        end

        @(negedge clk) rst_n = 0;
        hold(2);
        rst_n = 1;
        hold(1);
        en = 1;
        for (int f = 0; f < 3; f++) begin
            div_run(2, 14);
            div_run(4, 3);
            chk("forced_err", er0, 1);
            pulse_clr();
        end
`ifdef RATIO_MON_STATS_EN
        chk("fault_cnt3", fc0, 3);
`endif
        div_run(2, 6);

        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_hp", hp0, 0); chk("mid_rst_lk", lk0, 0);
        chk("mid_rst_er", er0, 0); chk("mid_rst_pv", pv0, 0);
`ifdef RATIO_MON_STATS_EN
        chk("mid_rst_fc", fc0, 0);
`endif
        hold(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_ratio_monitor.md
Name: clock_ratio_monitor

Overview:
Monitors a divided clock (typically the output of the team's clock divider) as a data signal in the clk domain.
- Synchronises the divided clock and measures each half-period in clk cycles.
- Declares lock after enough consecutive in-tolerance measurements against an expected divisor.
- Flags a sticky fault on ratio mismatch or a stopped clock.
- Sits beside clock generation logic as a built-in self-check.

Parameters:
- EXPECTED_DIV, 4: expected divide ratio; must be even and ≥ 2. Expected half-period HALF_EXP = EXPECTED_DIV/2.
- TOL, 0: allowed absolute deviation of a measured half-period from HALF_EXP, in clk cycles.
- LOCK_COUNT, 4: consecutive in-tolerance half-periods required to lock (≥ 1).
- TIMEOUT_CYCLES, 255: cycles without an edge before declaring the clock stopped. Counter width CNT_W = $clog2(TIMEOUT_CYCLES+1), a localparam.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  system reset.
- clk_in  input  1  monitored divided clock, asynchronous to the monitor.
- en  input  1  monitor enable, level.
- err_clr  input  1  single-cycle pulse; clears a fault.
- half_period  output  CNT_W  last measured half-period.
- period_valid  output  1  one-cycle pulse when half_period updates.
- locked  output  1  ratio confirmed.
- err  output  1  sticky fault flag.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs reset to 0; state=IDLE; internal counters 0; synchroniser flops 0.
- Input path: clk_in passes a 2-flop synchroniser, then a both-edge detector (XOR of synchronised value and its delayed copy). Edge-pulse latency from a clk_in change is 2–3 clk cycles.
- Cycle counter cnt:
  - On an edge cycle: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at TIMEOUT_CYCLES.
  - Example: clk_in toggling every 2 clk cycles measures 2.
- Measurement: on an edge in MEASURE or LOCKED, half_period <= cnt and period_valid pulses on the next cycle. No measurement is made on the first edge after SYNC.
- Match test: |cnt − HALF_EXP| ≤ TOL. Compute in CNT_W+1 bits; no wrap allowed.
- Timeout: cnt == TIMEOUT_CYCLES while in SYNC, MEASURE or LOCKED.
- FSM transitions:
  - Any state with en=0 → IDLE next cycle. Clears match_cnt, locked, cnt. err is kept.
  - IDLE, en=1 → SYNC.
  - SYNC: edge → MEASURE (match_cnt=0); timeout → FAULT.
  - MEASURE: edge + match → match_cnt++; reaching LOCK_COUNT → LOCKED (locked=1 the same cycle the state registers). Edge + mismatch → match_cnt=0, stay. Timeout → FAULT.
  - LOCKED: edge + match → stay. Edge + mismatch → FAULT. Timeout → FAULT.
  - FAULT: locked=0, err=1. err_clr → SYNC and err=0. Outside FAULT, err_clr is ignored.
- Simultaneous events:
  - Timeout and edge in the same cycle: the edge wins (measure cnt).
  - en=0 together with err_clr: en wins; err is still cleared if the state was FAULT.
- Reset mid-operation: immediate return to reset values; no partial measurement is reported.

Optional Feature:
RATIO_MON_STATS_EN
- Defined: adds output fault_cnt [7:0]. It increments on every entry to FAULT, saturates at 255, is cleared only by rst_n, and reads 0 after reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package clock_ratio_pkg: state enum (IDLE, SYNC, MEASURE, LOCKED, FAULT) and a width helper function for CNT_W.
- Sub-module sync_edge_detect: 2-flop synchroniser plus both-edge pulse; outputs the synchronised level and edge. Instantiated once.

Test Plan:
- EXPECTED_DIV=4, clk_in driven by a DIVISOR=4 divider, en=1 → half_period=2 on every valid, locked=1 after 4 matches, err=0.
- Locked, then divider switched to DIVISOR=8 → first half_period=4 gives FAULT, locked=0, err=1. err_clr pulse → SYNC, then relock after the divider returns to 4.
- clk_in held constant after lock, TIMEOUT_CYCLES=255 → err=1 exactly when cnt reaches 255; half_period unchanged.
- TOL=1, half-periods alternating 2 and 3 → lock achieved. With TOL=0 the same stimulus never locks and match_cnt keeps resetting.
- en dropped mid-MEASURE then re-raised → IDLE, then SYNC. First edge after re-enable gives no period_valid; lock requires 4 fresh matches.
- RATIO_MON_STATS_EN defined, 3 forced faults with err_clr between them → fault_cnt=3; assert rst_n=0 → fault_cnt=0.
